vram_rd_stream: RTL and testbench

- Read-side master for the camera frame buffer's port B (addrb/doutb, 1-cycle registered read latency).
- On a start pulse, scans one frame of 12-bit pixels in raster order.
- Emits pixels as a valid/ready stream with end-of-line and end-of-frame tags, feeding the SD-card writer or display path.
- Absorbs downstream backpressure without losing or duplicating pixels, despite the RAM read latency.

---
 rtl/vram_pkg.sv | 17 +
 rtl/vram_rd_stream_if.sv | 26 ++
 rtl/vram_rd_skid.sv | 79 +++++++
 rtl/vram_rd_stream.sv | 140 ++++++++++++++
 tb/tb_vram_rd_stream.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_pkg.sv
// Shared constants and FSM encoding for the VRAM port-B read streamer.
// The top-level parameters default to these values.
package vram_pkg;

    localparam int ADDR_W      = 14;
    localparam int DATA_W      = 12;
    localparam int H_PIX       = 128;
    localparam int V_LINES     = 96;
    localparam int FRAME_WORDS = H_PIX * V_LINES;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/vram_rd_stream_if.sv
// VRAM port-B read bus plus the tagged pixel stream.
// The master side is the read streamer; the slave side is RAM + sink.
interface vram_rd_stream_if #(
    parameter int ADDR_W = vram_pkg::ADDR_W,
    parameter int DATA_W = vram_pkg::DATA_W
);

    logic [ADDR_W-1:0] addrb;
    logic [DATA_W-1:0] doutb;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_eol;
    logic              m_eof;

    modport master (
        output addrb, m_data, m_valid, m_eol, m_eof,
        input  doutb, m_ready
    );

    modport slave (
        input  addrb, m_data, m_valid, m_eol, m_eof,
        output doutb, m_ready
    );

endinterface

// File: rtl/vram_rd_skid.sv
// Two-entry FIFO holding {eof, eol, data}; entry 0 is always the head,
// so the stream outputs come straight from a register.
module vram_rd_skid #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [1:0]   occ,
    output logic [W-1:0] head
);

    logic [W-1:0] e0_q, e0_d;
    logic [W-1:0] e1_q, e1_d;
    logic [1:0]   occ_q, occ_d;
    logic         do_pop;

    assign do_pop = pop && (occ_q != 2'd0);

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        occ_d = occ_q;
        if (flush) begin
            e0_d  = '0;
            e1_d  = '0;
            occ_d = 2'd0;
        end else begin
            case (occ_q)
                2'd0: begin
                    if (push) begin
                        e0_d  = din;
                        occ_d = 2'd1;
                    end
                end
                2'd1: begin
                    case ({push, do_pop})
                        2'b10: begin
                            e1_d  = din;
                            occ_d = 2'd2;
                        end
                        2'b01: occ_d = 2'd0;
                        2'b11: e0_d = din;
                        default: ;
                    endcase
                end
                2'd2: begin
                    // A push into a full buffer without a pop cannot occur:
                    // the issue rule reserves a slot for every read in flight.
                    if (do_pop) begin
                        e0_d = e1_q;
                        if (push) e1_d = din;
                        else      occ_d = 2'd1;
                    end
                end
                default: occ_d = 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0_q  <= '0;
            e1_q  <= '0;
            occ_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            occ_q <= occ_d;
        end
    end

    assign occ  = occ_q;
    assign head = e0_q;

endmodule

// File: rtl/vram_rd_stream.sv
// Raster-order frame reader for VRAM port B with a valid/ready pixel output.
// Reads are credit-limited so the 2-entry skid never overflows under stalls.
module vram_rd_stream
    import vram_pkg::*;
#(
    parameter int ADDR_W  = vram_pkg::ADDR_W,
    parameter int DATA_W  = vram_pkg::DATA_W,
    parameter int H_PIX   = vram_pkg::H_PIX,
    parameter int V_LINES = vram_pkg::V_LINES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    vram_rd_stream_if.master bus
);

    localparam int                FRAME     = H_PIX * V_LINES;
    localparam int                CW        = (H_PIX > 1) ? $clog2(H_PIX) : 1;
    localparam int                EW        = DATA_W + 2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME - 1);
    localparam logic [CW-1:0]     LAST_COL  = CW'(H_PIX - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addrb_q, addrb_d;
    logic [CW-1:0]     col_q, col_d;
    logic              inflight_q, inflight_d;
    logic              eol_p_q, eol_p_d;
    logic              eof_p_q, eof_p_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [1:0]    occ;
    logic [EW-1:0] head;
    logic          valid;
    logic          pop;
    logic          issue;
    logic [2:0]    credit;

    assign valid  = (occ != 2'd0);
    assign pop    = valid && bus.m_ready;
    assign credit = {1'b0, occ} + {2'b00, inflight_q};
    assign issue  = (state_q == RUN) && !abort && (credit < (3'd2 + {2'b00, pop}));

    vram_rd_skid #(.W(EW)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .flush (abort),
        .push  (inflight_q && !abort),
        .din   ({eof_p_q, eol_p_q, bus.doutb}),
        .pop   (pop),
        .occ   (occ),
        .head  (head)
    );

    always_comb begin
        state_d    = state_q;
        addrb_d    = addrb_q;
        col_d      = col_q;
        eol_p_d    = eol_p_q;
        eof_p_d    = eof_p_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        inflight_d = issue;

        // Tags describe the address the RAM samples on this edge.
        if (issue) begin
            addrb_d = addrb_q + 1'b1;
            col_d   = (col_q == LAST_COL) ? '0 : col_q + 1'b1;
            eol_p_d = (col_q == LAST_COL);
            eof_p_d = (addrb_q == LAST_ADDR);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    addrb_d = '0;
                    col_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                if (issue && (addrb_q == LAST_ADDR)) state_d = DRAIN;
            end
            DRAIN: begin
                if (pop && head[EW-1]) begin
                    state_d = IDLE;
                    addrb_d = '0;
                    col_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d    = IDLE;
            addrb_d    = '0;
            col_d      = '0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addrb_q    <= '0;
            col_q      <= '0;
            inflight_q <= 1'b0;
            eol_p_q    <= 1'b0;
            eof_p_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addrb_q    <= addrb_d;
            col_q      <= col_d;
            inflight_q <= inflight_d;
            eol_p_q    <= eol_p_d;
            eof_p_q    <= eof_p_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.addrb   = addrb_q;
    assign bus.m_valid = valid;
    assign bus.m_data  = head[DATA_W-1:0];
    assign bus.m_eol   = valid && head[DATA_W];
    assign bus.m_eof   = valid && head[DATA_W+1];
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_vram_rd_stream.sv
// Bench for vram_rd_stream: small 4x2 frame, behavioural RAM and a pixel-list
// reference model built directly from the raster/tag rules.
module tb_vram_rd_stream;

    localparam int AW = 6;
    localparam int DW = 12;
    localparam int HP = 4;
    localparam int VL = 2;
    localparam int FR = HP * VL;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic abort;
    logic busy;
    logic done;

    vram_rd_stream_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    vram_rd_stream #(.ADDR_W(AW), .DATA_W(DW), .H_PIX(HP), .V_LINES(VL)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) bus.doutb <= mem[bus.addrb];

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] got_d[$];
    bit            got_l[$];
    bit            got_f[$];
    int            hs_i[$];
    int done_cnt, done_at, first_valid, stable_viol, drop_viol, ovf_viol;
    logic          busy_at_done;
    logic [AW-1:0] addr_at_done, addr9;

    task automatic preload(input bit rnd);
        for (int i = 0; i < (1 << AW); i++)
            mem[i] = rnd ? DW'($urandom) : DW'(i + 'h100);
    endtask

    // Runs one frame from a start pulse; records handshakes and stream-rule violations.
    task automatic collect(input int mode, input int budget, input bit repulse);
        logic pv, pr, pl, pf, rdy;
        logic [DW-1:0] pdat;
        got_d.delete(); got_l.delete(); got_f.delete(); hs_i.delete();
        done_cnt = 0; done_at = -1; first_valid = -1;
        stable_viol = 0; drop_viol = 0; ovf_viol = 0;
        busy_at_done = 1'b1; addr_at_done = '1; addr9 = '1;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pf = 1'b0; pdat = '0;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            start = repulse && (i == 5);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((i % 4) == 0) || ((i % 4) == 3);
                2:       rdy = 1'($urandom_range(0, 1));
                default: rdy = (i >= 10);
            endcase
            bus.m_ready = rdy;
            #1;
            if (pv && !pr) begin
                if (!bus.m_valid) drop_viol++;
                else if (bus.m_data !== pdat || bus.m_eol !== pl || bus.m_eof !== pf) stable_viol++;
            end
            if (u_dut.u_skid.push && !u_dut.u_skid.pop && u_dut.u_skid.occ == 2'd2) ovf_viol++;
            if (u_dut.u_skid.occ > 2'd2) ovf_viol++;
            if (bus.m_valid && first_valid < 0) first_valid = i;
            if (bus.m_valid && rdy) begin
                got_d.push_back(bus.m_data);
                got_l.push_back(bus.m_eol);
                got_f.push_back(bus.m_eof);
                hs_i.push_back(i);
            end
            if (i == 9) addr9 = bus.addrb;
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = i;
                    busy_at_done = busy;
                    addr_at_done = bus.addrb;
                end
            end
            pv = bus.m_valid; pr = rdy; pdat = bus.m_data; pl = bus.m_eol; pf = bus.m_eof;
            if (done_at >= 0 && i >= done_at + 3) break;
        end
        start = 1'b0;
        bus.m_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++; if (bus.addrb !== '0)   begin n_fail++; $display("FAIL reset_addrb: got %0h want 0", bus.addrb); end
        n_checks++; if (bus.m_valid !== 0)  begin n_fail++; $display("FAIL reset_valid: got %0b want 0", bus.m_valid); end
        n_checks++; if (bus.m_data !== '0)  begin n_fail++; $display("FAIL reset_data: got %0h want 0", bus.m_data); end
        n_checks++; if (bus.m_eol !== 0)    begin n_fail++; $display("FAIL reset_eol: got %0b want 0", bus.m_eol); end
        n_checks++; if (bus.m_eof !== 0)    begin n_fail++; $display("FAIL reset_eof: got %0b want 0", bus.m_eof); end
        n_checks++; if (busy !== 0)         begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_checks++; if (done !== 0)         begin n_fail++; $display("FAIL reset_done: got %0b want 0", done); end
    endtask

    task automatic test_full_throughput();
        preload(1'b0);
        collect(0, 60, 1'b0);
        n_checks++; if (first_valid != 2) begin n_fail++; $display("FAIL ft_latency: got %0d want 2", first_valid); end
        n_checks++; if (got_d.size() != FR) begin n_fail++; $display("FAIL ft_count: got %0d want %0d", got_d.size(), FR); end
        for (int k = 0; k < FR && k < got_d.size(); k++) begin
            n_checks++;
            if (got_d[k] !== DW'('h100 + k) || got_l[k] !== ((k % HP) == HP - 1) ||
                got_f[k] !== (k == FR - 1) || hs_i[k] != 2 + k) begin
                n_fail++;
                $display("FAIL ft_pixel%0d: got d=%0h eol=%0b eof=%0b cyc=%0d want d=%0h eol=%0b eof=%0b cyc=%0d",
                         k, got_d[k], got_l[k], got_f[k], hs_i[k], 'h100 + k,
                         (k % HP) == HP - 1, k == FR - 1, 2 + k);
            end
        end
        n_checks++; if (done_cnt != 1)      begin n_fail++; $display("FAIL ft_done_cnt: got %0d want 1", done_cnt); end
        n_checks++; if (done_at != FR + 2)  begin n_fail++; $display("FAIL ft_done_cycle: got %0d want %0d", done_at, FR + 2); end
        n_checks++; if (busy_at_done !== 0) begin n_fail++; $display("FAIL ft_busy_at_done: got %0b want 0", busy_at_done); end
        n_checks++; if (addr_at_done !== '0) begin n_fail++; $display("FAIL ft_addr_at_done: got %0h want 0", addr_at_done); end
    endtask

    task automatic test_backpressure();
        preload(1'b0);
        collect(1, 120, 1'b0);
        n_checks++; if (got_d.size() != FR) begin n_fail++; $display("FAIL bp_count: got %0d want %0d", got_d.size(), FR); end
        for (int k = 0; k < FR && k < got_d.size(); k++) begin
            n_checks++;
            if (got_d[k] !== DW'('h100 + k) || got_l[k] !== ((k % HP) == HP - 1) || got_f[k] !== (k == FR - 1)) begin
                n_fail++;
                $display("FAIL bp_pixel%0d: got d=%0h eol=%0b eof=%0b want d=%0h", k, got_d[k], got_l[k], got_f[k], 'h100 + k);
            end
        end
        n_checks++; if (stable_viol != 0) begin n_fail++; $display("FAIL bp_stable: got %0d violations want 0", stable_viol); end
        n_checks++; if (drop_viol != 0)   begin n_fail++; $display("FAIL bp_valid_drop: got %0d want 0", drop_viol); end
        n_checks++; if (ovf_viol != 0)    begin n_fail++; $display("FAIL bp_overflow: got %0d want 0", ovf_viol); end
        n_checks++; if (done_cnt != 1)    begin n_fail++; $display("FAIL bp_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_stall_start();
        preload(1'b0);
        collect(3, 120, 1'b0);
        n_checks++; if (addr9 !== AW'(2)) begin n_fail++; $display("FAIL stall_addrb: got %0d want 2", addr9); end
        n_checks++; if (got_d.size() != FR) begin n_fail++; $display("FAIL stall_count: got %0d want %0d", got_d.size(), FR); end
        for (int k = 0; k < FR && k < got_d.size(); k++) begin
            n_checks++;
            if (got_d[k] !== DW'('h100 + k) || (k > 0 && hs_i[k] != hs_i[k-1] + 1)) begin
                n_fail++;
                $display("FAIL stall_pixel%0d: got d=%0h cyc=%0d want d=%0h consecutive", k, got_d[k], hs_i[k], 'h100 + k);
            end
        end
        n_checks++; if (stable_viol != 0 || drop_viol != 0 || ovf_viol != 0) begin
            n_fail++; $display("FAIL stall_rules: got stable=%0d drop=%0d ovf=%0d want 0", stable_viol, drop_viol, ovf_viol);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            preload(1'b1);
            collect(2, 400, 1'b0);
            n_checks++; if (got_d.size() != FR) begin n_fail++; $display("FAIL rnd%0d_count: got %0d want %0d", r, got_d.size(), FR); end
            for (int a = 0; a < FR && a < got_d.size(); a++) begin
                n_checks++;
                if (got_d[a] !== mem[a] || got_l[a] !== ((a % HP) == HP - 1) || got_f[a] !== (a == FR - 1)) begin
                    n_fail++;
                    $display("FAIL rnd%0d_pixel%0d: got d=%0h eol=%0b eof=%0b want d=%0h", r, a, got_d[a], got_l[a], got_f[a], mem[a]);
                end
            end
            n_checks++; if (stable_viol != 0 || drop_viol != 0 || ovf_viol != 0 || done_cnt != 1) begin
                n_fail++; $display("FAIL rnd%0d_rules: got stable=%0d drop=%0d ovf=%0d done=%0d want 0/0/0/1",
                                   r, stable_viol, drop_viol, ovf_viol, done_cnt);
            end
        end
    endtask

    task automatic test_ignored_start();
        preload(1'b0);
        collect(0, 60, 1'b1);
        n_checks++; if (got_d.size() != FR) begin n_fail++; $display("FAIL restart_count: got %0d want %0d", got_d.size(), FR); end
        for (int k = 0; k < FR && k < got_d.size(); k++) begin
            n_checks++;
            if (got_d[k] !== DW'('h100 + k)) begin n_fail++; $display("FAIL restart_pixel%0d: got %0h want %0h", k, got_d[k], 'h100 + k); end
        end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL restart_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_abort();
        int hs, dn;
        bit aborted;
        logic rdy;
        preload(1'b0);
        hs = 0; aborted = 0; dn = 0;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            start = 1'b0;
            rdy = (hs < 4);
            bus.m_ready = rdy;
            #1;
            if (bus.m_valid && hs == 4) begin
                n_checks++; if (bus.m_data !== DW'('h104)) begin n_fail++; $display("FAIL abort_5th: got %0h want 104", bus.m_data); end
                abort = 1'b1;
                aborted = 1;
                @(negedge clk);
                abort = 1'b0;
                #1;
                n_checks++; if (bus.m_valid !== 0) begin n_fail++; $display("FAIL abort_valid: got %0b want 0", bus.m_valid); end
                n_checks++; if (busy !== 0)        begin n_fail++; $display("FAIL abort_busy: got %0b want 0", busy); end
                n_checks++; if (bus.addrb !== '0)  begin n_fail++; $display("FAIL abort_addrb: got %0h want 0", bus.addrb); end
                break;
            end
            if (bus.m_valid && rdy) hs++;
        end
        n_checks++; if (!aborted) begin n_fail++; $display("FAIL abort_reach: got timeout want 5th pixel"); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.m_ready = 1'b1;
            #1;
            if (done) dn++;
        end
        bus.m_ready = 1'b0;
        n_checks++; if (dn != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", dn); end
        collect(0, 60, 1'b0);
        n_checks++; if (got_d.size() != FR || got_d[0] !== DW'('h100) || got_d[FR-1] !== DW'('h107)) begin
            n_fail++; $display("FAIL abort_replay: got n=%0d first=%0h want n=%0d first=100 last=107",
                               got_d.size(), got_d.size() > 0 ? got_d[0] : '0, FR);
        end
    endtask

    task automatic test_reset_midframe();
        int dn;
        dn = 0;
        preload(1'b0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bus.m_ready = 1'b1;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus.m_valid !== 0 || busy !== 0 || bus.addrb !== '0 || bus.m_data !== '0 ||
                        bus.m_eol !== 0 || bus.m_eof !== 0 || done !== 0) begin
            n_fail++; $display("FAIL rst_mid_values: got v=%0b busy=%0b a=%0h d=%0h want all 0",
                               bus.m_valid, busy, bus.addrb, bus.m_data);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            if (done || busy) dn++;
        end
        bus.m_ready = 1'b0;
        n_checks++; if (dn != 0) begin n_fail++; $display("FAIL rst_mid_quiet: got %0d busy/done cycles want 0", dn); end
        collect(0, 60, 1'b0);
        n_checks++; if (got_d.size() != FR || done_cnt != 1) begin
            n_fail++; $display("FAIL rst_mid_recover: got n=%0d done=%0d want n=%0d done=1", got_d.size(), done_cnt, FR);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        bus.m_ready = 1'b0;
        preload(1'b0);
        #12;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        test_full_throughput();
        test_backpressure();
        test_stall_start();
        test_ignored_start();
        test_abort();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
